// File: rtl/seven_bag_randomizer.sv
// 7-bag piece randomizer: draws 3-bit candidates from the LFSR bit stream by rejection
// sampling, deals each type 0..6 once per bag, and buffers dealt pieces in a preview queue.
module seven_bag_randomizer #(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rand_bit,
  input  logic                               flush,
  input  logic                               piece_pop,
  output logic                               piece_valid,
  output logic [2:0]                         piece_head,
  output logic [3*QUEUE_DEPTH-1:0]           preview,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic [6:0]                         bag_used
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FILL, EVAL, EVAL_FORCED} state_t;

  state_t        state;
  logic [1:0]    bit_cnt;
  logic [2:0]    cand;
  logic [2:0]    fifo [QUEUE_DEPTH];
  logic [CW-1:0] count;

  logic [2:0]    forced_type;
  logic [2:0]    used_cnt;
  logic [7:0]    used_ext;
  logic          accept;
  logic          push;
  logic          pop_ok;
  logic [2:0]    push_type;
  logic [6:0]    used_next;
  logic [AW-1:0] wr_idx;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    forced_type = 3'd0;
    used_cnt    = 3'd0;
    for (int k = 0; k < 7; k++) begin
      used_cnt = used_cnt + {2'b00, bag_used[k]};
      if (!bag_used[k]) forced_type = 3'(k);
    end
    // Candidate 7 maps onto the always-set top bit, so it rejects like a dealt type.
    used_ext  = {1'b1, bag_used};
    accept    = (state == EVAL) && !used_ext[cand];
    push      = accept || (state == EVAL_FORCED);
    push_type = (state == EVAL_FORCED) ? forced_type : cand;
    pop_ok    = piece_pop && (count != '0);
    used_next = bag_used | (7'd1 << push_type);
    if (used_next == 7'h7F) used_next = 7'h00;
    wr_idx    = AW'(count - CW'(pop_ok));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 2'd0;
      cand     <= 3'd0;
      count    <= '0;
      bag_used <= 7'h00;
      // NOTE: the queue is tiny, so it is reset too; vacated entries then always hold 0.
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo[i] <= 3'd0;
    end else if (flush) begin
      state    <= IDLE;
      bit_cnt  <= 2'd0;
      cand     <= 3'd0;
      count    <= '0;
      bag_used <= 7'h00;
      for (int i = 0; i < QUEUE_DEPTH; i++) fifo[i] <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (count == CW'(QUEUE_DEPTH)) begin
            state <= IDLE;
          end else if (used_cnt == 3'd6) begin
            state <= EVAL_FORCED;
          end else begin
            state   <= FILL;
            bit_cnt <= 2'd0;
          end
        end
        FILL: begin
          cand <= {cand[1:0], rand_bit};
          if (bit_cnt == 2'd2) begin
            bit_cnt <= 2'd0;
            state   <= EVAL;
          end else begin
            bit_cnt <= bit_cnt + 2'd1;
          end
        end
        EVAL, EVAL_FORCED: state <= IDLE;
        default:           state <= IDLE;
      endcase

      if (push) bag_used <= used_next;

      // Pop shifts toward the head; a same-edge push then overwrites the slot at count-1.
      if (pop_ok) begin
        for (int i = 0; i < QUEUE_DEPTH - 1; i++) fifo[i] <= fifo[i+1];
        fifo[QUEUE_DEPTH-1] <= 3'd0;
      end
      if (push) fifo[wr_idx] <= push_type;

      count <= count + CW'(push) - CW'(pop_ok);
    end
  end

  always_comb begin
    preview = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (CW'(i) < count) preview[3*i +: 3] = fifo[i];
    end
    piece_valid = (count != '0);
    piece_head  = piece_valid ? fifo[0] : 3'd0;
    queue_count = count;
  end

endmodule

// File: tb/tb_seven_bag_randomizer.sv
// Directed bench for seven_bag_randomizer: a queue of expected pieces plus an expected
// bag set are updated as draws are driven and compared against the DUT after every edge.
module tb_seven_bag_randomizer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             rand_bit;
  logic             flush;
  logic             piece_pop;
  logic             piece_valid;
  logic [2:0]       piece_head;
  logic [3*DEPTH-1:0] preview;
  logic [CW-1:0]    queue_count;
  logic [6:0]       bag_used;

  seven_bag_randomizer #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rand_bit    (rand_bit),
    .flush       (flush),
    .piece_pop   (piece_pop),
    .piece_valid (piece_valid),
    .piece_head  (piece_head),
    .preview     (preview),
    .queue_count (queue_count),
    .bag_used    (bag_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [2:0] exp_q[$];
  logic [6:0] exp_used = 7'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark_dealt(input logic [2:0] t);
    exp_q.push_back(t);
    exp_used[t] = 1'b1;
    if (exp_used == 7'h7F) exp_used = 7'h00;
  endtask

  task automatic check_state(input string tag);
    logic [3*DEPTH-1:0] p;
    p = '0;
    for (int i = 0; i < exp_q.size() && i < DEPTH; i++) p[3*i +: 3] = exp_q[i];
    chk({tag, ".count"},   32'(queue_count), 32'(exp_q.size()));
    chk({tag, ".valid"},   32'(piece_valid), 32'(exp_q.size() != 0));
    chk({tag, ".head"},    32'(piece_head),  (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    chk({tag, ".preview"}, 32'(preview),     32'(p));
    chk({tag, ".bag"},     32'(bag_used),    32'(exp_used));
  endtask

  // Head is compared when it is consumed; the DUT removes it at the coming edge.
  task automatic arm_pop(input logic en);
    piece_pop = en;
    if (en && exp_q.size() != 0) chk("pop_head", 32'(piece_head), 32'(exp_q.pop_front()));
  endtask

  // One draw from IDLE: IDLE edge, three FILL edges (MSB first), EVAL edge.
  task automatic draw(input logic [2:0] bits, input logic pop_first, input logic pop_last,
                      input string tag);
    logic accepts;
    int   cnt_before;
    rand_bit = ~bits[2];
    arm_pop(pop_first);
    step();
    piece_pop = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      rand_bit = bits[i];
      step();
    end
    if (bits == 3'd7) accepts = 1'b0;
    else              accepts = !exp_used[bits];
    cnt_before = exp_q.size();
    chk({tag, ".pre_eval_count"}, 32'(queue_count), 32'(cnt_before));
    rand_bit = 1'($urandom);
    arm_pop(pop_last);
    step();
    piece_pop = 1'b0;
    if (accepts) mark_dealt(bits);
    check_state(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    piece_pop = 1'b0;
    rand_bit  = 1'b0;
    #1;
    check_state("reset");
    step();
    step();
    rst = 1'b0;
    check_state("reset_release");

    // 1: candidate 7 rejected, then type 2 accepted
    draw(3'b111, 1'b0, 1'b0, "t1_reject7");
    draw(3'b010, 1'b0, 1'b0, "t1_accept2");

    // 2: duplicate rejected
    draw(3'b010, 1'b0, 1'b0, "t2_dup");

    // 3/4: fill to depth, then park with the bag frozen
    draw(3'b000, 1'b0, 1'b0, "t3_type0");
    draw(3'b001, 1'b0, 1'b0, "t3_type1");
    draw(3'b011, 1'b0, 1'b0, "t3_type3");
    for (int i = 0; i < 6; i++) begin
      rand_bit = 1'($urandom);
      step();
      check_state("t4_parked");
    end
    arm_pop(1'b1);
    step();
    piece_pop = 1'b0;
    check_state("t4_pop");
    draw(3'b100, 1'b0, 1'b0, "t3_type4");
    arm_pop(1'b1);
    step();
    piece_pop = 1'b0;
    check_state("t3_pop2");
    draw(3'b101, 1'b0, 1'b0, "t3_type5");

    // Six types dealt: one pop frees a slot, forced draw of 6 takes two edges and wraps the bag
    arm_pop(1'b1);
    step();
    piece_pop = 1'b0;
    check_state("t3_pop3");
    rand_bit = 1'b1;
    step();
    chk("t3_forced_wait", 32'(queue_count), 32'd3);
    step();
    mark_dealt(3'd6);
    check_state("t3_forced");

    // 5: pop coinciding with the EVAL accept keeps count at 2
    arm_pop(1'b1);
    step();
    piece_pop = 1'b0;
    check_state("t5_pop");
    draw(3'b010, 1'b1, 1'b1, "t5_pop_push");

    // 6a: flush together with pop while FILL has consumed one bit
    rand_bit = 1'b0;
    step();
    rand_bit = 1'b1;
    step();
    flush     = 1'b1;
    piece_pop = 1'b1;
    step();
    flush     = 1'b0;
    piece_pop = 1'b0;
    exp_q.delete();
    exp_used = 7'h00;
    check_state("t6_flush");
    draw(3'b011, 1'b0, 1'b0, "t6_after_flush");

    // 6b: async reset while in EVAL with an acceptable candidate
    rand_bit = 1'b0;
    step();
    for (int i = 2; i >= 0; i--) begin
      rand_bit = (3'b101 >> i) & 3'b001;
      step();
    end
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_used = 7'h00;
    check_state("t6_async_rst");
    step();
    rst = 1'b0;
    check_state("t6_rst_release");
    draw(3'b110, 1'b0, 1'b0, "t6_after_rst");

    arm_pop(1'b1);
    step();
    piece_pop = 1'b0;
    check_state("drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
